// File: rtl/tile_pkg.sv
// Shared constants and FSM encoding for the 2048 board tile store.
// Used by tile_bank and tile_store_arbiter (TILE_DBUF_EN selects double buffering there).
package tile_pkg;

    localparam int N_TILES = 16;
    localparam int TILE_W  = 4;
    localparam int ADDR_W  = 4;

    // Exponent 0 marks an empty cell.
    localparam logic [TILE_W-1:0] TILE_EMPTY = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UPD  = 3'd1,
        ST_PEND = 3'd2,
        ST_SWAP = 3'd3,
        ST_COPY = 3'd4
    } tile_state_e;

endpackage

// File: rtl/tile_bank.sv
// 16-entry tile exponent register file: one registered read port, one write port.
// Contents and read register clear to empty on reset.
module tile_bank
    import tile_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [TILE_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [TILE_W-1:0] wdata_i
);

    logic [N_TILES-1:0][TILE_W-1:0] mem_q;
    logic [TILE_W-1:0]              rdata_q;

    // Cell storage: single write per cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= TILE_EMPTY;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tile_store_arbiter.sv
// Board tile store shared between the VGA renderer (reads, strict priority)
// and the game logic (writes during an update window).
// Define TILE_DBUF_EN for a front/back bank pair that swaps at frame start;
// without it a single bank is written in place.
module tile_store_arbiter
    import tile_pkg::*;
(
    input  logic              dclk,
    input  logic              clr_n,
    input  logic              frame_start,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [TILE_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              upd_start,
    input  logic              upd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [TILE_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              busy,
    output logic              front_sel,
    output logic              swap_pulse
);

    tile_state_e state_q;
    logic        rd_valid_q;
    logic        grant;

    // Game write only wins when the renderer leaves the slot free.
    assign grant    = (state_q == ST_UPD) && wr_req && !rd_req;
    assign wr_ack   = grant;
    assign busy     = (state_q != ST_IDLE);
    assign rd_valid = rd_valid_q;

`ifdef TILE_DBUF_EN
    logic                         front_q;
    logic                         sel_q;
    logic                         copy_wr_q;
    logic [ADDR_W-1:0]            cnt_q;
    logic [ADDR_W-1:0]            copy_addr_q;
    logic                         copy_issue;
    logic                         bank_re;
    logic [ADDR_W-1:0]            bank_raddr;
    logic [ADDR_W-1:0]            bank_waddr;
    logic [TILE_W-1:0]            bank_wdata;
    logic [1:0]                   bank_we;
    logic [1:0][TILE_W-1:0]       bank_rdata;

    // Copy borrows the shared read port only in cycles the renderer leaves idle.
    assign copy_issue = (state_q == ST_COPY) && !rd_req;
    assign bank_re    = rd_req || copy_issue;
    assign bank_raddr = copy_issue ? cnt_q : rd_addr;

    // Copy write lands one cycle after its read, using the registered read data.
    assign bank_waddr = copy_wr_q ? copy_addr_q : wr_addr;
    assign bank_wdata = copy_wr_q ? rd_data : wr_data;

    // Read data follows the bank that was front when the read was issued.
    assign rd_data    = sel_q ? bank_rdata[1] : bank_rdata[0];
    assign front_sel  = front_q;
    assign swap_pulse = (state_q == ST_SWAP);

    for (genvar k = 0; k < 2; k++) begin : g_bank
        localparam logic KB = 1'(k);
        // Writes always target the back bank (the one not shown).
        assign bank_we[k] = (grant || copy_wr_q) && (front_q != KB);

        tile_bank u_bank (
            .clk_i   (dclk),
            .rst_n_i (clr_n),
            .re_i    (bank_re),
            .raddr_i (bank_raddr),
            .rdata_o (bank_rdata[k]),
            .we_i    (bank_we[k]),
            .waddr_i (bank_waddr),
            .wdata_i (bank_wdata)
        );
    end

    // Read-side and copy pipeline registers.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            rd_valid_q  <= 1'b0;
            sel_q       <= 1'b0;
            copy_wr_q   <= 1'b0;
            copy_addr_q <= '0;
        end else begin
            rd_valid_q  <= rd_req;
            sel_q       <= front_q;
            copy_wr_q   <= copy_issue;
            copy_addr_q <= cnt_q;
        end
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;

    tile_bank u_bank (
        .clk_i   (dclk),
        .rst_n_i (clr_n),
        .re_i    (rd_req),
        .raddr_i (rd_addr),
        .rdata_o (rd_data),
        .we_i    (grant),
        .waddr_i (wr_addr),
        .wdata_i (wr_data)
    );

    assign front_sel  = 1'b0;
    assign swap_pulse = 1'b0;

    // Read valid trails the request by one cycle.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
        end
    end
`endif

    // Update / swap / copy sequencer.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
`ifdef TILE_DBUF_EN
            front_q <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (upd_start) state_q <= ST_UPD;
`ifdef TILE_DBUF_EN
                ST_UPD:  if (upd_done) state_q <= ST_PEND;
                // A frame_start coinciding with upd_done is not seen here, so the swap waits a frame.
                ST_PEND: if (frame_start) state_q <= ST_SWAP;
                ST_SWAP: begin
                    front_q <= ~front_q;
                    cnt_q   <= '0;
                    state_q <= ST_COPY;
                end
                // Bring the new back bank level with the front so later partial updates stay coherent.
                ST_COPY: if (copy_issue) begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(N_TILES - 1)) state_q <= ST_IDLE;
                end
`else
                ST_UPD:  if (upd_done) state_q <= ST_IDLE;
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_store_arbiter.sv
// Directed bench for tile_store_arbiter; double-buffer steps run only when TILE_DBUF_EN is defined.
module tb_tile_store_arbiter;

    logic       dclk = 1'b0;
    logic       clr_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       rd_req = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       upd_start = 1'b0;
    logic       upd_done = 1'b0;
    logic       wr_req = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_ack;
    logic       busy;
    logic       front_sel;
    logic       swap_pulse;

    int total = 0;
    int bad   = 0;

    tile_store_arbiter dut (
        .dclk        (dclk),
        .clr_n       (clr_n),
        .frame_start (frame_start),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .upd_start   (upd_start),
        .upd_done    (upd_done),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .busy        (busy),
        .front_sel   (front_sel),
        .swap_pulse  (swap_pulse)
    );

    always #5 dclk = ~dclk;

    task automatic cyc();
        @(posedge dclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One-cycle read; checks valid and data on the following cycle.
    task automatic rd(input string tag, input logic [3:0] a, input logic [3:0] exp);
        rd_req  = 1'b1;
        rd_addr = a;
        cyc();
        rd_req = 1'b0;
        chk({tag, "_vld"}, rd_valid, 1);
        chk(tag, rd_data, exp);
    endtask

    // Single write inside an open update window, renderer idle.
    task automatic wr(input string tag, input logic [3:0] a, input logic [3:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        chk(tag, wr_ack, 1);
        cyc();
        wr_req = 1'b0;
    endtask

    task automatic pulse_start();
        upd_start = 1'b1;
        cyc();
        upd_start = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_front", front_sel, 0);
        chk("rst_swap", swap_pulse, 0);
        chk("rst_wr_ack", wr_ack, 0);
        clr_n = 1'b1;
        cyc();

        // 1. read addr 5 after reset
        rd("t1_rd5", 4'd5, 4'd0);
        cyc();
        chk("t1_vld_drop", rd_valid, 0);

        // 2. write blocked while renderer reads
        pulse_start();
        chk("t2_busy", busy, 1);
        rd_req  = 1'b1;
        rd_addr = 4'd0;
        wr_req  = 1'b1;
        wr_addr = 4'd3;
        wr_data = 4'h2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_ack_blocked", wr_ack, 0);
            cyc();
        end
        rd_req = 1'b0;
        #1;
        chk("t2_ack_free", wr_ack, 1);
        cyc();
        wr_req = 1'b0;
        #1;
        chk("t2_ack_after", wr_ack, 0);

`ifdef TILE_DBUF_EN
        // 3. write sits in back bank until the swap
        rd("t3_rd3_upd", 4'd3, 4'd0);
        upd_done = 1'b1;
        cyc();
        upd_done = 1'b0;
        chk("t3_pend_busy", busy, 1);
        rd("t3_rd3_pend", 4'd3, 4'd0);
        wr_req = 1'b1;
        #1;
        chk("t3_pend_no_ack", wr_ack, 0);
        wr_req = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("t3_swap", swap_pulse, 1);
        chk("t3_front_old", front_sel, 0);
        rd_req  = 1'b1;
        rd_addr = 4'd3;
        cyc();
        chk("t3_swap_once", swap_pulse, 0);
        chk("t3_front_new", front_sel, 1);
        chk("t3_rd_in_swap", rd_data, 0);
        cyc();
        chk("t3_rd3_new", rd_data, 2);

        // 4. copy stalls under reads, then needs 16 free cycles
        repeat (5) cyc();
        chk("t4_stall_busy", busy, 1);
        rd_req = 1'b0;
        repeat (15) cyc();
        chk("t4_busy_15", busy, 1);
        cyc();
        chk("t4_busy_16", busy, 0);
        pulse_start();
        wr("t4_wr7", 4'd7, 4'd3);
        upd_done = 1'b1;
        cyc();
        upd_done = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        chk("t4_front0", front_sel, 0);
        rd("t4_rd3_kept", 4'd3, 4'd2);
        rd("t4_rd7_new", 4'd7, 4'd3);
        for (int k = 0; k < 40 && busy; k++) cyc();
        chk("t4_copy_done", busy, 0);

        // 5. same-cycle upd_done and frame_start: swap waits a frame
        pulse_start();
        upd_done    = 1'b1;
        frame_start = 1'b1;
        cyc();
        upd_done    = 1'b0;
        frame_start = 1'b0;
        chk("t5_no_swap", swap_pulse, 0);
        chk("t5_pend_busy", busy, 1);
        repeat (3) cyc();
        chk("t5_still_no_swap", swap_pulse, 0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("t5_swap", swap_pulse, 1);

        // 6. reset in the middle of the copy
        cyc();
        repeat (8) cyc();
        chk("t6_busy_mid", busy, 1);
        chk("t6_front_mid", front_sel, 1);
        clr_n = 1'b0;
        #2;
        chk("t6_busy_rst", busy, 0);
        chk("t6_front_rst", front_sel, 0);
        clr_n = 1'b1;
        cyc();
        for (int a = 0; a < 16; a++) rd("t6_cell", 4'(a), 4'd0);
`else
        // single bank: write visible immediately
        rd("s_rd3_upd", 4'd3, 4'd2);
        upd_done = 1'b1;
        cyc();
        upd_done = 1'b0;
        chk("s_idle", busy, 0);
        wr_req  = 1'b1;
        wr_addr = 4'd3;
        wr_data = 4'h9;
        #1;
        chk("s_idle_no_ack", wr_ack, 0);
        repeat (2) cyc();
        chk("s_idle_no_ack2", wr_ack, 0);
        wr_req = 1'b0;
        rd("s_rd3_kept", 4'd3, 4'd2);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("s_no_swap", swap_pulse, 0);
        chk("s_front", front_sel, 0);
        chk("s_fs_busy", busy, 0);

        // reset mid-update loses the board
        pulse_start();
        wr("s_wr9", 4'd9, 4'd5);
        rd("s_rd9", 4'd9, 4'd5);
        clr_n = 1'b0;
        #2;
        chk("s_busy_rst", busy, 0);
        clr_n = 1'b1;
        cyc();
        rd("s_rd9_rst", 4'd9, 4'd0);
        rd("s_rd3_rst", 4'd3, 4'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
